// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: round sequencer for one 512-bit SHA-256 block.
// Holds the working registers A..H, a 16-word sliding message-schedule
// window and the K table, and drives an external combinational round datapath.
// The chaining value is added back in at the end of the block, and the
// resulting digest is held until the consumer accepts it.
module sha256_round_ctrl #(
   parameter int BIT_W  = 32,
   parameter int ROUNDS = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             blk_valid,
   output logic             blk_ready,
   input  logic [511:0]     blk_data,
   input  logic [255:0]     hash_in,
   output logic [5:0]       round_idx,
   output logic [BIT_W-1:0] k_out,
   output logic [BIT_W-1:0] w_out,
   output logic [BIT_W-1:0] a_q,
   output logic [BIT_W-1:0] b_q,
   output logic [BIT_W-1:0] c_q,
   output logic [BIT_W-1:0] d_q,
   output logic [BIT_W-1:0] e_q,
   output logic [BIT_W-1:0] f_q,
   output logic [BIT_W-1:0] g_q,
   output logic [BIT_W-1:0] h_q,
   input  logic [BIT_W-1:0] a_nx,
   input  logic [BIT_W-1:0] b_nx,
   input  logic [BIT_W-1:0] c_nx,
   input  logic [BIT_W-1:0] d_nx,
   input  logic [BIT_W-1:0] e_nx,
   input  logic [BIT_W-1:0] f_nx,
   input  logic [BIT_W-1:0] g_nx,
   input  logic [BIT_W-1:0] h_nx,
   output logic             busy,
   output logic             digest_valid,
   input  logic             digest_ready,
   output logic [255:0]     digest_out
);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   state_t           state;
   state_t           state_nx;
   logic [5:0]       t_q;
   logic [BIT_W-1:0] w_win [16];
   logic [BIT_W-1:0] chain [8];
   logic [BIT_W-1:0] w_new;
   logic             accept;

   function automatic logic [BIT_W-1:0] ror(input logic [BIT_W-1:0] x, input int n);
      return (x >> n) | (x << (BIT_W - n));
   endfunction

   function automatic logic [BIT_W-1:0] sig0(input logic [BIT_W-1:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [BIT_W-1:0] sig1(input logic [BIT_W-1:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   assign accept = (state == IDLE) && blk_valid;

   // Window slot 0 is W[t]; the word entering slot 15 is W[t+16].
   assign w_new = sig1(w_win[14]) + w_win[9] + sig0(w_win[1]) + w_win[0];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic and handshake/datapath-facing outputs.
   always_comb begin
      state_nx     = state;
      blk_ready    = 1'b0;
      busy         = 1'b0;
      digest_valid = 1'b0;
      round_idx    = '0;
      k_out        = '0;
      w_out        = '0;
      case (state)
         IDLE: begin
            blk_ready = 1'b1;
            if (blk_valid) state_nx = ROUND;
         end
         ROUND: begin
            busy      = 1'b1;
            round_idx = t_q;
            k_out     = K_TAB[t_q];
            w_out     = w_win[0];
            if (t_q == LAST_T) state_nx = FINAL;
         end
         FINAL: begin
            busy     = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            digest_valid = 1'b1;
            if (digest_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Round counter: cleared on accept, wraps 63->0 as ROUND is left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_q <= '0;
      end else if (accept) begin
         t_q <= '0;
      end else if (state == ROUND) begin
         t_q <= t_q + 6'd1;
      end
   end

   // Working registers A..H and the chaining copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
         for (int i = 0; i < 8; i++) chain[i] <= '0;
      end else if (accept) begin
         {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= hash_in;
         for (int i = 0; i < 8; i++) chain[i] <= hash_in[(7 - i) * BIT_W +: BIT_W];
      end else if (state == ROUND) begin
         {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= {a_nx, b_nx, c_nx, d_nx, e_nx, f_nx, g_nx, h_nx};
      end
   end

   // Message-schedule window: loaded with the block, shifts once per round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) w_win[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < 16; i++) w_win[i] <= blk_data[(15 - i) * BIT_W +: BIT_W];
      end else if (state == ROUND) begin
         for (int i = 0; i < 15; i++) w_win[i] <= w_win[i + 1];
         w_win[15] <= w_new;
      end
   end

   // Digest: chaining value plus final registers, word-wise with no carry between words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digest_out <= '0;
      end else if (state == FINAL) begin
         digest_out <= {chain[0] + a_q, chain[1] + b_q, chain[2] + c_q, chain[3] + d_q,
                        chain[4] + e_q, chain[5] + f_q, chain[6] + g_q, chain[7] + h_q};
      end
   end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: self-checking bench for the SHA-256 round sequencer.
// Supplies a combinational round datapath, a whole-block reference model
// (full 64-word schedule and per-round states) and a phase model of the handshake.
module tb_sha256_round_ctrl;

   localparam logic [31:0] KB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV         = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC_DIG    = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_DIG  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [511:0] ABC_BLK    = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK  = {32'h80000000, 480'h0};

   logic         clk;
   logic         rst_n;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic [255:0] hash_in;
   logic [5:0]   round_idx;
   logic [31:0]  k_out, w_out;
   logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
   logic [31:0]  a_nx, b_nx, c_nx, d_nx, e_nx, f_nx, g_nx, h_nx;
   logic         busy;
   logic         digest_valid;
   logic         digest_ready;
   logic [255:0] digest_out;

   int checks = 0;
   int passes = 0;

   // Reference results for the block currently in flight.
   logic [31:0]  ref_w     [64];
   logic [255:0] ref_state [65];
   logic [255:0] ref_digest;

   // -1 idle, 0..63 round t, 64 final, 65 digest held.
   int phase = -1;

   logic [31:0] obs_k0, obs_k63, obs_w16;

   sha256_round_ctrl #(.BIT_W(32), .ROUNDS(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .hash_in(hash_in),
      .round_idx(round_idx), .k_out(k_out), .w_out(w_out),
      .a_q(a_q), .b_q(b_q), .c_q(c_q), .d_q(d_q),
      .e_q(e_q), .f_q(f_q), .g_q(g_q), .h_q(h_q),
      .a_nx(a_nx), .b_nx(b_nx), .c_nx(c_nx), .d_nx(d_nx),
      .e_nx(e_nx), .f_nx(f_nx), .g_nx(g_nx), .h_nx(h_nx),
      .busy(busy), .digest_valid(digest_valid),
      .digest_ready(digest_ready), .digest_out(digest_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i * 32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] rand_hash();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i * 32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference round datapath driven by the controller.
   always_comb begin
      {a_nx, b_nx, c_nx, d_nx, e_nx, f_nx, g_nx, h_nx} =
         sha_round({a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q}, k_out, w_out);
   end

   task automatic compute_ref(input logic [511:0] blk, input logic [255:0] hin);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) ref_w[t] = blk[511 - 32 * t -: 32];
         else ref_w[t] = (ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10)) + ref_w[t-7]
                       + (ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3)) + ref_w[t-16];
      end
      ref_state[0] = hin;
      for (int t = 0; t < 64; t++) ref_state[t+1] = sha_round(ref_state[t], KB[t], ref_w[t]);
      for (int i = 0; i < 8; i++)
         ref_digest[i * 32 +: 32] = hin[i * 32 +: 32] + ref_state[64][i * 32 +: 32];
   endtask

   task automatic check_output(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, " blk_ready"}, 256'(blk_ready), 256'd1);
      check_output({tag, " busy"}, 256'(busy), 256'd0);
      check_output({tag, " digest_valid"}, 256'(digest_valid), 256'd0);
      check_output({tag, " round_idx"}, 256'(round_idx), 256'd0);
      check_output({tag, " k_out"}, 256'(k_out), 256'd0);
      check_output({tag, " w_out"}, 256'(w_out), 256'd0);
      check_output({tag, " regs"}, {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q}, 256'd0);
      check_output({tag, " digest_out"}, digest_out, 256'd0);
   endtask

   // Phase model of the handshake, advanced on every active edge.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) phase = -1;
      else if (phase == -1) begin
         if (blk_valid) phase = 0;
      end else if (phase <= 64) phase = phase + 1;
      else if (digest_ready) phase = -1;
   end

   // Per-cycle comparison of every DUT output against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check_output("blk_ready", 256'(blk_ready), 256'(phase == -1));
         check_output("busy", 256'(busy), 256'(phase >= 0 && phase <= 64));
         check_output("digest_valid", 256'(digest_valid), 256'(phase == 65));
         check_output("round_idx", 256'(round_idx), (phase >= 0 && phase < 64) ? 256'(phase) : 256'd0);
         check_output("k_out", 256'(k_out), (phase >= 0 && phase < 64) ? 256'(KB[phase]) : 256'd0);
         check_output("w_out", 256'(w_out), (phase >= 0 && phase < 64) ? 256'(ref_w[phase]) : 256'd0);
         if (phase >= 0 && phase <= 64)
            check_output("regs", {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q}, ref_state[phase]);
         if (phase == 65) check_output("digest_out", digest_out, ref_digest);
         if (phase == 0)  obs_k0  = k_out;
         if (phase == 63) obs_k63 = k_out;
         if (phase == 16) obs_w16 = w_out;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!blk_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("ready wait", 256'(blk_ready), 256'd1);
   endtask

   task automatic apply_stimulus(input logic [511:0] blk, input logic [255:0] hin, input int hold,
                                 input bit junk, output logic [255:0] dig);
      int lat;
      compute_ref(blk, hin);
      wait_ready();
      blk_data  = blk;
      hash_in   = hin;
      blk_valid = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      lat = 0;
      while (!digest_valid && lat < 200) begin
         if (junk) begin
            blk_valid    = 1'($urandom);
            blk_data     = rand_block();
            hash_in      = rand_hash();
            digest_ready = 1'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      blk_valid    = 1'b0;
      digest_ready = 1'b0;
      dig = digest_out;
      check_output("latency", 256'(lat), 256'd65);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_output("hold digest", digest_out, dig);
         check_output("hold valid", 256'(digest_valid), 256'd1);
         check_output("hold blk_ready", 256'(blk_ready), 256'd0);
      end
      digest_ready = 1'b1;
      @(posedge clk); #1;
      digest_ready = 1'b0;
      check_output("post xfer blk_ready", 256'(blk_ready), 256'd1);
      check_output("post xfer valid", 256'(digest_valid), 256'd0);
   endtask

   initial begin
      logic [255:0] dig;
      rst_n        = 1'b0;
      blk_valid    = 1'b0;
      digest_ready = 1'b0;
      blk_data     = '0;
      hash_in      = '0;
      #1;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // "abc" with a held-off consumer and junk on the block input during rounds.
      apply_stimulus(ABC_BLK, IV, 10, 1'b1, dig);
      check_output("abc digest", dig, ABC_DIG);
      check_output("model abc digest", ref_digest, ABC_DIG);
      check_output("model abc w16", 256'(ref_w[16]), 256'h61626380);
      check_output("obs w16", 256'(obs_w16), 256'h61626380);
      check_output("obs k0", 256'(obs_k0), 256'h428a2f98);
      check_output("obs k63", 256'(obs_k63), 256'hc67178f2);

      // Empty message, immediate accept.
      apply_stimulus(EMPTY_BLK, IV, 0, 1'b0, dig);
      check_output("empty digest", dig, EMPTY_DIG);

      // Random blocks and chaining values.
      for (int r = 0; r < 3; r++) begin
         apply_stimulus(rand_block(), rand_hash(), int'($urandom_range(0, 3)), 1'b1, dig);
         check_output("random digest", dig, ref_digest);
      end

      // Abort at round 30 with an asynchronous reset pulse.
      compute_ref(ABC_BLK, IV);
      wait_ready();
      blk_data  = ABC_BLK;
      hash_in   = IV;
      blk_valid = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
      end
      check_output("abort round", 256'(round_idx), 256'd30);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid reset");
      @(posedge clk); #1;
      check_reset_outputs("held reset");
      rst_n = 1'b1;

      apply_stimulus(ABC_BLK, IV, 2, 1'b0, dig);
      check_output("abc after reset", dig, ABC_DIG);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
